// File: rtl/btb_upd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : btb_upd_ctrl_if
// Brief    : Branch-resolution update channel and BTB write-port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface btb_upd_ctrl_if #(
    parameter int INDEX_WIDTH = 8
);
    logic                   upd_valid;
    logic                   upd_ready;
    logic [31:0]            upd_pc;
    logic [31:0]            upd_tpc;
    logic                   upd_taken;
    logic                   upd_add_fail;
    logic                   upd_dir_fail;
    logic                   btb_we;
    logic [INDEX_WIDTH-1:0] btb_widx;
    logic [31:0]            btb_wdata;
    logic                   btb_wvld;

    // Execute side produces results and observes the BTB write port.
    modport master (
        output upd_valid, upd_pc, upd_tpc, upd_taken, upd_add_fail, upd_dir_fail,
        input  upd_ready, btb_we, btb_widx, btb_wdata, btb_wvld
    );

    modport slave (
        input  upd_valid, upd_pc, upd_tpc, upd_taken, upd_add_fail, upd_dir_fail,
        output upd_ready, btb_we, btb_widx, btb_wdata, btb_wvld
    );
endinterface
`default_nettype wire

// File: rtl/btb_upd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btb_upd_ctrl
// Brief    : BTB write-side controller: coalescing update queue plus flush sweep.
// Revision : 1.0 - initial release
// ============================================================================
module btb_upd_ctrl #(
    parameter int INDEX_WIDTH = 8,
    parameter int QDEPTH      = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    btb_upd_ctrl_if.slave     bus,
    input  wire logic         flush_req,
    output logic              flush_busy,
    output logic [15:0]       coal_cnt
);
    localparam int c_PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [c_PW:0] c_FULL = (c_PW + 1)'(QDEPTH);
    localparam logic [c_PW:0] c_ONE  = (c_PW + 1)'(1);
    localparam logic [INDEX_WIDTH:0] c_SWEEP_END = {1'b1, {INDEX_WIDTH{1'b0}}};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_SWEEP = 2'd2;

    logic [1:0]             r_state,  w_nxt_state;
    logic [c_PW:0]          r_count,  w_nxt_count;
    logic [c_PW-1:0]        r_head,   w_nxt_head;
    logic [c_PW-1:0]        r_tail,   w_nxt_tail;
    logic [INDEX_WIDTH:0]   r_sweep,  w_nxt_sweep;
    logic                   r_we,     w_nxt_we;
    logic [INDEX_WIDTH-1:0] r_widx,   w_nxt_widx;
    logic [31:0]            r_wdata,  w_nxt_wdata;
    logic                   r_wvld,   w_nxt_wvld;
    logic                   r_flush_busy;
    logic [15:0]            r_coal;

    logic [INDEX_WIDTH-1:0] r_q_idx  [QDEPTH];
    logic [31:0]            r_q_data [QDEPTH];
    logic                   r_q_vld  [QDEPTH];

    logic                   w_full;
    logic                   w_accept;
    logic                   w_worthy;
    logic                   w_pop;
    logic                   w_coal;
    logic                   w_bypass;
    logic                   w_enq;
    logic [INDEX_WIDTH-1:0] w_uidx;
    logic [c_PW-1:0]        w_tail_last;
    logic                   w_unused_pc;

    assign w_full      = (r_count == c_FULL);
    assign w_uidx      = bus.upd_pc[INDEX_WIDTH+2:3];
    assign w_unused_pc = ^{bus.upd_pc[31:INDEX_WIDTH+3], bus.upd_pc[2:0]};
    assign w_tail_last = r_tail - c_PW'(1);

    assign bus.upd_ready = !w_full && (r_state != c_SWEEP) && !flush_req;
    assign w_accept      = bus.upd_valid && bus.upd_ready;
    assign w_worthy      = w_accept && (bus.upd_add_fail || bus.upd_dir_fail);
    assign w_pop         = (r_count != '0) && !flush_req && (r_state != c_SWEEP);

    // The tail may only absorb a push when it is not also the entry leaving this cycle.
    assign w_coal   = w_worthy && (r_count > c_ONE) && (r_q_idx[w_tail_last] == w_uidx);
    assign w_bypass = w_worthy && (r_count == '0);
    assign w_enq    = w_worthy && !w_coal && !w_bypass;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_count = r_count;
        w_nxt_head  = r_head;
        w_nxt_tail  = r_tail;
        w_nxt_sweep = r_sweep;
        w_nxt_we    = 1'b0;
        w_nxt_widx  = r_widx;
        w_nxt_wdata = r_wdata;
        w_nxt_wvld  = r_wvld;

        if (flush_req) begin
            w_nxt_state = c_SWEEP;
            w_nxt_count = '0;
            w_nxt_head  = '0;
            w_nxt_tail  = '0;
            w_nxt_we    = 1'b1;
            w_nxt_widx  = '0;
            w_nxt_wdata = '0;
            w_nxt_wvld  = 1'b0;
            w_nxt_sweep = (INDEX_WIDTH + 1)'(1);
        end else if (r_state == c_SWEEP) begin
            if (r_sweep == c_SWEEP_END) begin
                w_nxt_state = c_IDLE;
            end else begin
                w_nxt_we    = 1'b1;
                w_nxt_widx  = r_sweep[INDEX_WIDTH-1:0];
                w_nxt_wdata = '0;
                w_nxt_wvld  = 1'b0;
                w_nxt_sweep = r_sweep + (INDEX_WIDTH + 1)'(1);
            end
        end else begin
            if (w_pop) begin
                w_nxt_we    = 1'b1;
                w_nxt_widx  = r_q_idx[r_head];
                w_nxt_wdata = r_q_data[r_head];
                w_nxt_wvld  = r_q_vld[r_head];
                w_nxt_head  = r_head + c_PW'(1);
            end else if (w_bypass) begin
                // Empty queue: the result goes straight to the write register.
                w_nxt_we    = 1'b1;
                w_nxt_widx  = w_uidx;
                w_nxt_wdata = bus.upd_tpc;
                w_nxt_wvld  = bus.upd_taken;
            end
            if (w_enq) begin
                w_nxt_tail = r_tail + c_PW'(1);
            end
            w_nxt_count = r_count + (c_PW + 1)'(w_enq) - (c_PW + 1)'(w_pop);
            w_nxt_state = (w_nxt_count != '0) ? c_DRAIN : c_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_count      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_sweep      <= '0;
            r_we         <= 1'b0;
            r_widx       <= '0;
            r_wdata      <= '0;
            r_wvld       <= 1'b0;
            r_flush_busy <= 1'b0;
            r_coal       <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_count      <= w_nxt_count;
            r_head       <= w_nxt_head;
            r_tail       <= w_nxt_tail;
            r_sweep      <= w_nxt_sweep;
            r_we         <= w_nxt_we;
            r_widx       <= w_nxt_widx;
            r_wdata      <= w_nxt_wdata;
            r_wvld       <= w_nxt_wvld;
            r_flush_busy <= (w_nxt_state == c_SWEEP);
            if (w_coal && (r_coal != 16'hFFFF)) begin
                r_coal <= r_coal + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_idx[r_tail]  <= w_uidx;
            r_q_data[r_tail] <= bus.upd_tpc;
            r_q_vld[r_tail]  <= bus.upd_taken;
        end
        if (w_coal) begin
            r_q_data[w_tail_last] <= bus.upd_tpc;
            r_q_vld[w_tail_last]  <= bus.upd_taken;
        end
    end

    assign bus.btb_we    = r_we;
    assign bus.btb_widx  = r_widx;
    assign bus.btb_wdata = r_wdata;
    assign bus.btb_wvld  = r_wvld;
    assign flush_busy    = r_flush_busy;
    assign coal_cnt      = r_coal;
endmodule
`default_nettype wire
